// File: rtl/sort_result_serializer.sv
// sort_result_serializer: buffers 4-wide sorted frames in a small FIFO and streams them out one element per beat.
//
// Ports:
//   clk                       clock, all logic on the rising edge
//   rst                       asynchronous active-low reset (0 = reset)
//   x_valid                   one-cycle frame strobe from the sorting network
//   x_0..x_3                  sorted frame elements
//   x_label_0..x_label_3      labels paired with x_0..x_3
//   m_valid/m_ready           output element handshake
//   m_data, m_label           current element and its label
//   m_index                   element position within its frame (0..3)
//   m_last                    high on element 3 of a frame
//   overflow                  one-cycle pulse after an incoming frame is dropped
//   frame_count               frames currently held
//   order_err                 (SORT_SER_ORDER_CHECK_EN only) one-cycle pulse after a
//                             frame whose elements are out of the expected order
//
// Optional feature macro: SORT_SER_ORDER_CHECK_EN adds the order_err output and its comparators.
module sort_result_serializer #(
    parameter int DATA_WIDTH  = 8,
    parameter int LABEL_WIDTH = 1,
    parameter int DEPTH       = 2,
    parameter int SIGNED      = 0,
    parameter int ASCENDING   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     x_valid,
    input  logic [DATA_WIDTH-1:0]    x_0,
    input  logic [DATA_WIDTH-1:0]    x_1,
    input  logic [DATA_WIDTH-1:0]    x_2,
    input  logic [DATA_WIDTH-1:0]    x_3,
    input  logic [LABEL_WIDTH-1:0]   x_label_0,
    input  logic [LABEL_WIDTH-1:0]   x_label_1,
    input  logic [LABEL_WIDTH-1:0]   x_label_2,
    input  logic [LABEL_WIDTH-1:0]   x_label_3,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_WIDTH-1:0]    m_data,
    output logic [LABEL_WIDTH-1:0]   m_label,
    output logic [1:0]               m_index,
    output logic                     m_last,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   frame_count
`ifdef SORT_SER_ORDER_CHECK_EN
    ,
    output logic                     order_err
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0]  data_mem  [DEPTH][4];
    logic [LABEL_WIDTH-1:0] label_mem [DEPTH][4];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic [1:0]             idx;
    logic                   beat;
    logic                   pop;
    logic                   full;
    logic                   push;

    // True when a precedes-or-equals b in the configured sort direction.
    function automatic logic in_order(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
        logic le;
        logic ge;
        le = (SIGNED != 0) ? ($signed(a) <= $signed(b)) : (a <= b);
        ge = (SIGNED != 0) ? ($signed(a) >= $signed(b)) : (a >= b);
        return (ASCENDING != 0) ? le : ge;
    endfunction

    assign beat = m_valid & m_ready;
    assign pop  = beat & (idx == 2'd3);
    assign full = count == CW'(DEPTH);
    // A full FIFO still accepts a frame when the head frame leaves on the same edge.
    assign push = x_valid & (~full | pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            idx      <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= x_valid & ~push;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (beat)
                idx <= idx + 2'd1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Frame storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr][0]  <= x_0;
            data_mem[wr_ptr][1]  <= x_1;
            data_mem[wr_ptr][2]  <= x_2;
            data_mem[wr_ptr][3]  <= x_3;
            label_mem[wr_ptr][0] <= x_label_0;
            label_mem[wr_ptr][1] <= x_label_1;
            label_mem[wr_ptr][2] <= x_label_2;
            label_mem[wr_ptr][3] <= x_label_3;
        end
    end

    // idx is always 0 while the FIFO is empty, so index/last need no masking.
    assign m_valid     = count != '0;
    assign m_data      = m_valid ? data_mem[rd_ptr][idx] : '0;
    assign m_label     = m_valid ? label_mem[rd_ptr][idx] : '0;
    assign m_index     = idx;
    assign m_last      = idx == 2'd3;
    assign frame_count = count;

`ifdef SORT_SER_ORDER_CHECK_EN
    // Checked on every strobe, whether or not the frame is stored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            order_err <= 1'b0;
        else
            order_err <= x_valid & ~(in_order(x_0, x_1) & in_order(x_1, x_2) & in_order(x_2, x_3));
    end
`endif

endmodule
